// File: rtl/fetch_stage.sv
// IF stage: owns the PC, single-outstanding imem req/ack, one-entry skid buffer, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetched_count / bubble_count outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchPCOffset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFIDIR,
  output logic [31:0] IFIDPC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetched_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        ack_s;
  logic        ack_busy_s;
  logic        try_launch_s;
  logic        load_word_s;
  logic        load_bubble_s;

  // Next-state: IF/ID load, skid buffer, PC and request FSM
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    buf_valid_d   = buf_valid_q;
    buf_word_d    = buf_word_q;
    buf_pc_d      = buf_pc_q;
    ir_d          = ir_q;
    pc_d          = pc_q;
    try_launch_s  = 1'b0;
    load_word_s   = 1'b0;
    load_bubble_s = 1'b0;
    ack_s         = imem_ack && (state_q != ST_IDLE);
    ack_busy_s    = ack_s && (state_q == ST_BUSY);

    if (stall) begin
      if (ack_busy_s) begin
        buf_valid_d = 1'b1;
        buf_word_d  = imem_rdata;
        buf_pc_d    = req_addr_q + 32'd4;
        fetch_pc_d  = req_addr_q + 32'd4;
      end else begin
        buf_valid_d = buf_valid_q;
      end
    end else if (branchTaken) begin
      ir_d          = NOP_WORD;
      load_bubble_s = 1'b1;
      fetch_pc_d    = pc_q + branchPCOffset;
      buf_valid_d   = 1'b0;
    end else if (buf_valid_q) begin
      // Buffered word goes first; a simultaneous ack word refills the buffer
      ir_d        = buf_word_q;
      pc_d        = buf_pc_q;
      load_word_s = 1'b1;
      if (ack_busy_s) begin
        buf_word_d = imem_rdata;
        buf_pc_d   = req_addr_q + 32'd4;
        fetch_pc_d = req_addr_q + 32'd4;
      end else begin
        buf_valid_d = 1'b0;
      end
    end else if (ack_busy_s) begin
      ir_d        = imem_rdata;
      pc_d        = req_addr_q + 32'd4;
      fetch_pc_d  = req_addr_q + 32'd4;
      load_word_s = 1'b1;
    end else begin
      ir_d          = NOP_WORD;
      load_bubble_s = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        try_launch_s = 1'b1;
      end
      ST_BUSY, ST_DROP: begin
        if (ack_s) begin
          try_launch_s = 1'b1;
        end else if (!stall && branchTaken) begin
          state_d = ST_DROP;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (try_launch_s) begin
      if (!buf_valid_d) begin
        state_d    = ST_BUSY;
        req_addr_d = fetch_pc_d;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      req_addr_d = req_addr_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_word_q  <= NOP_WORD;
      buf_pc_q    <= RESET_PC + 32'd4;
      ir_q        <= NOP_WORD;
      pc_q        <= RESET_PC + 32'd4;
    end else begin
      state_q     <= state_d;
      req_q       <= (state_d != ST_IDLE);
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_pc_q    <= buf_pc_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = req_addr_q;
  assign IFIDIR    = ir_q;
  assign IFIDPC    = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] bubble_q;

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= 32'd0;
      bubble_q  <= 32'd0;
    end else begin
      fetched_q <= fetched_q + {31'd0, load_word_s};
      bubble_q  <= bubble_q + {31'd0, load_bubble_s};
    end
  end

  assign fetched_count = fetched_q;
  assign bubble_count  = bubble_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = load_word_s ^ load_bubble_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/branch/latency
// checked against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchPCOffset = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] IFIDIR;
  logic [31:0] IFIDPC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_count;
  logic [31:0] bubble_count;
`endif

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branchTaken    (branchTaken),
    .branchPCOffset (branchPCOffset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .IFIDIR         (IFIDIR),
    .IFIDPC         (IFIDPC)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_count  (fetched_count),
    .bubble_count   (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] p;
  } ent_t;

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_ir, m_pc, m_fetch, m_out_addr;
  logic        m_out_valid, m_out_wanted;
  logic [31:0] m_fetched, m_bubbles;

  int n_assert = 0;
  int n_fail = 0;
  int lat = 0;
  int wait_cnt = 0;
  bit rand_lat = 1'b0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h0000_1000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ir = NOP;
    m_pc = 32'd4;
    m_fetch = 32'd0;
    m_out_addr = 32'd0;
    m_out_valid = 1'b0;
    m_out_wanted = 1'b0;
    m_fetched = 32'd0;
    m_bubbles = 32'd0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] off,
                            input logic ack, input logic [31:0] rd);
    ent_t e;
    logic ackv, got;
    ackv = ack && m_out_valid;
    got = ackv && m_out_wanted;
    if (st) begin
      if (got) begin
        e.w = rd; e.p = m_out_addr + 32'd4; mq.push_back(e); m_fetch = m_out_addr + 32'd4;
      end
    end else if (br) begin
      m_ir = NOP;
      m_fetch = m_pc + off;
      mq.delete();
      m_bubbles++;
      if (m_out_valid && !ackv) m_out_wanted = 1'b0;
    end else begin
      if (got) begin
        e.w = rd; e.p = m_out_addr + 32'd4; mq.push_back(e); m_fetch = m_out_addr + 32'd4;
      end
      if (mq.size() > 0) begin
        e = mq.pop_front(); m_ir = e.w; m_pc = e.p; m_fetched++;
      end else begin
        m_ir = NOP; m_bubbles++;
      end
    end
    if (ackv) m_out_valid = 1'b0;
    if (!m_out_valid && mq.size() == 0) begin
      m_out_valid = 1'b1; m_out_addr = m_fetch; m_out_wanted = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_out_valid});
    if (m_out_valid) chk("imem_addr", imem_addr, m_out_addr);
    chk("IFIDIR", IFIDIR, m_ir);
    chk("IFIDPC", IFIDPC, m_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("fetched_count", fetched_count, m_fetched);
    chk("bubble_count", bubble_count, m_bubbles);
`endif
  endtask

  task automatic cycle_raw(input logic st, input logic br, input logic [31:0] off,
                           input logic ack, input logic [31:0] rd);
    stall = st; branchTaken = br; branchPCOffset = off; imem_ack = ack; imem_rdata = rd;
    model_step(st, br, off, ack, rd);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic cycle(input logic st, input logic br, input logic [31:0] off);
    logic ack;
    logic [31:0] rd;
    ack = 1'b0;
    if (imem_req === 1'b1) begin
      if (wait_cnt >= lat) begin
        ack = 1'b1;
        wait_cnt = 0;
        if (rand_lat) lat = int'($urandom_range(0, 3));
      end else begin
        wait_cnt++;
      end
    end
    rd = ack ? memword(imem_addr) : 32'hDEAD_BEEF;
    cycle_raw(st, br, off, ack, rd);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    stall = 1'b0; branchTaken = 1'b0; branchPCOffset = 32'd0; imem_ack = 1'b0;
    #1;
    chk("rst_IFIDIR", IFIDIR, NOP);
    chk("rst_IFIDPC", IFIDPC, 32'd4);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetched", fetched_count, 32'd0);
    chk("rst_bubble", bubble_count, 32'd0);
`endif
    model_reset();
    wait_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int o;
    logic [31:0] off;
    #2;
    apply_reset();

    // zero-latency streaming, then stall while word 8 is acked
    lat = 0;
    cycle(1'b0, 1'b0, 32'd0);
    chk("A_req0", imem_addr, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("A_ir0", IFIDIR, 32'h0000_1000);
    chk("A_pc0", IFIDPC, 32'd4);
    cycle(1'b0, 1'b0, 32'd0);
    chk("A_ir1", IFIDIR, 32'h0000_1004);
    chk("A_addr8", imem_addr, 32'd8);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0040);
    cycle(1'b1, 1'b0, 32'd0);
    chk("A_stall_ir", IFIDIR, 32'h0000_1004);
    chk("A_stall_req", {31'd0, imem_req}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("A_rel_ir", IFIDIR, 32'h0000_1008);
    chk("A_rel_pc", IFIDPC, 32'd12);
    chk("A_rel_addr", imem_addr, 32'd12);
    cycle(1'b0, 1'b0, 32'd0);
    chk("A_ir3", IFIDIR, 32'h0000_100C);

    // three-cycle ack latency
    lat = 2;
    wait_cnt = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'd0);

    // taken branch squashes an in-flight fetch
    apply_reset();
    lat = 1;
    n = 0;
    while (IFIDPC !== 32'h0000_0010 && n < 40) begin
      cycle(1'b0, 1'b0, 32'd0);
      n++;
    end
    chk("C_pc10", IFIDPC, 32'h0000_0010);
    cycle(1'b0, 1'b1, 32'h0000_0020);
    chk("C_squash_ir", IFIDIR, NOP);
    cycle(1'b0, 1'b0, 32'd0);
    chk("C_target_addr", imem_addr, 32'h0000_0030);
    chk("C_target_req", {31'd0, imem_req}, 32'd1);
    n = 0;
    while (IFIDIR === NOP && n < 10) begin
      cycle(1'b0, 1'b0, 32'd0);
      n++;
    end
    chk("C_target_ir", IFIDIR, 32'h0000_1030);
    chk("C_target_pc", IFIDPC, 32'h0000_0034);

    // reset asserted mid-request; a late ack must be ignored
    lat = 3;
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    apply_reset();
    cycle_raw(1'b0, 1'b0, 32'd0, 1'b1, 32'h0BAD_0BAD);
    chk("D_ir_after", IFIDIR, NOP);
    chk("D_addr_after", imem_addr, 32'd0);
    wait_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0);

    // randomized stall / branch / latency against the model
    rand_lat = 1'b1;
    lat = int'($urandom_range(0, 3));
    for (int i = 0; i < 500; i++) begin
      o = int'($urandom_range(0, 32)) - 16;
      off = 32'(o * 4);
      cycle(($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, off);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
